geared_stream_collect_buf: RTL and testbench

Buffered N-to-1 stream collector for the memory island's geared datapaths. It accepts up to `NumLanes` parallel valid/ready streams, holds each lane's beats in a private FIFO of `Depth` entries, and merges them onto one output stream in a single clock domain. The lane order is either round-robin or strict time-division (TDM). It sits between the multi-ported bank side and the single-ported narrow side. This replaces the unbuffered, two-clock gear collector wherever both sides run on the same clock.

---
 rtl/geared_stream_collect_buf.sv | 173 +++++++++++++++++
 tb/tb_geared_stream_collect_buf.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/geared_stream_collect_buf.sv
// geared_stream_collect_buf
//
// Buffered N-to-1 stream collector. Each input lane has a private registered
// FIFO of Depth entries. The lane heads are merged onto one output stream,
// either round-robin (Mode 0) or by strict TDM slot rotation (Mode 1).
// Everything runs on a single clock.
//
// Parameters
//   NumLanes  number of input lanes (>= 1)
//   Depth     entries per lane FIFO (>= 1)
//   Mode      0 = round-robin, 1 = TDM slot
//   T         payload type (packed)
//
// Ports
//   clk_i     clock, rising edge
//   rst_ni    synchronous active-low reset
//   clr_i     synchronous clear; beats presented in the same cycle are dropped
//   valid_i / ready_o / data_i   per-lane input streams
//   valid_o / ready_i / data_o   merged output stream
//   slot_o    lane index currently presented on the output
//   fill_o    per-lane FIFO occupancy; present only when
//             GEARED_COLLECT_BUF_OCCUPANCY_EN is defined
//
// ready_o depends on registered lane counts only. There is no combinational
// path from ready_i to ready_o, and no path from valid_i to valid_o.

module geared_stream_collect_buf #(
    parameter int unsigned NumLanes = 2,
    parameter int unsigned Depth    = 2,
    parameter int unsigned Mode     = 0,
    parameter type         T        = logic,
    localparam int unsigned SlotW   = (NumLanes > 1) ? $clog2(NumLanes) : 1,
    localparam int unsigned CntW    = $clog2(Depth + 1),
    localparam int unsigned PtrW    = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic [NumLanes-1:0]   valid_i,
    output logic [NumLanes-1:0]   ready_o,
    input  T     [NumLanes-1:0]   data_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output T                      data_o,
    output logic [SlotW-1:0]      slot_o
`ifdef GEARED_COLLECT_BUF_OCCUPANCY_EN
    ,
    output logic [NumLanes-1:0][CntW-1:0] fill_o
`endif
);

    // Adds k to lane index b, modulo NumLanes.
    function automatic logic [SlotW-1:0] lane_add(input logic [SlotW-1:0] b, input int k);
        return SlotW'((int'(b) + k) % int'(NumLanes));
    endfunction

    logic [NumLanes-1:0] push, pop, nonempty;
    T                    head [NumLanes];

    logic [SlotW-1:0]    sel;        // lane presented on the output
    logic                valid;
    logic                hs;         // output handshake this cycle

    // ------------------------------------------------------------------
    // Lane FIFOs
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NumLanes; i++) begin : g_lane
        T                mem_q [Depth];
        logic [PtrW-1:0] wp_q, rp_q;
        logic [CntW-1:0] cnt_q, cnt_d;

        // A full lane refuses the push even if it pops this cycle.
        assign ready_o[i]  = (cnt_q != CntW'(Depth));
        assign push[i]     = valid_i[i] & ready_o[i] & ~clr_i;
        assign pop[i]      = hs & (sel == SlotW'(i)) & ~clr_i;
        assign nonempty[i] = (cnt_q != '0);
        assign head[i]     = mem_q[rp_q];

        always_comb begin
            cnt_d = cnt_q;
            case ({push[i], pop[i]})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end

        always_ff @(posedge clk_i) begin
            if (!rst_ni || clr_i) begin
                wp_q  <= '0;
                rp_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (push[i]) wp_q <= (wp_q == PtrW'(Depth - 1)) ? '0 : wp_q + 1'b1;
                if (pop[i])  rp_q <= (rp_q == PtrW'(Depth - 1)) ? '0 : rp_q + 1'b1;
                cnt_q <= cnt_d;
            end
        end

        // Storage needs no reset: a slot is only read after it was written.
        always_ff @(posedge clk_i) begin
            if (push[i]) mem_q[wp_q] <= data_i[i];
        end

`ifdef GEARED_COLLECT_BUF_OCCUPANCY_EN
        assign fill_o[i] = cnt_q;
`endif
    end

    // ------------------------------------------------------------------
    // Scheduler
    // sched_q is the round-robin pointer in Mode 0 and the TDM slot in
    // Mode 1. The lock only matters in Mode 0: once a beat is offered and
    // stalled, the grant is held so that a lane filling up in front of it
    // cannot change slot_o/data_o before the handshake.
    // ------------------------------------------------------------------
    logic [SlotW-1:0] sched_q, sched_d;
    logic             lock_q, lock_d;
    logic [SlotW-1:0] lock_lane_q, lock_lane_d;
    logic [SlotW-1:0] rr_grant;
    logic             found;

    always_comb begin
        // First non-empty lane at or after the pointer; the pointer itself
        // when nothing is pending.
        rr_grant = sched_q;
        found    = 1'b0;
        for (int k = 0; k < int'(NumLanes); k++) begin
            if (!found && nonempty[lane_add(sched_q, k)]) begin
                rr_grant = lane_add(sched_q, k);
                found    = 1'b1;
            end
        end

        if (Mode == 0) begin
            sel   = lock_q ? lock_lane_q : rr_grant;
            valid = |nonempty;
        end else begin
            sel   = sched_q;
            valid = nonempty[sched_q];
        end
        hs = valid & ready_i;

        sched_d     = sched_q;
        lock_d      = 1'b0;
        lock_lane_d = lock_lane_q;
        if (Mode == 0) begin
            if (hs) sched_d = lane_add(sel, 1);
            lock_d      = valid & ~ready_i;
            lock_lane_d = sel;
        end else begin
            // The slot advances every cycle, empty or not, unless stalled.
            if (!(valid && !ready_i)) sched_d = lane_add(sched_q, 1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            sched_q     <= '0;
            lock_q      <= 1'b0;
            lock_lane_q <= '0;
        end else begin
            sched_q     <= sched_d;
            lock_q      <= lock_d;
            lock_lane_q <= lock_lane_d;
        end
    end

    assign valid_o = valid;
    assign slot_o  = sel;
    assign data_o  = head[sel];

endmodule

// File: tb/tb_geared_stream_collect_buf.sv
// Testbench for geared_stream_collect_buf: one round-robin instance and one
// TDM instance (4 lanes, depth 2, 8-bit payload). Expected output beats are
// queued as stimulus is driven and compared on every output handshake;
// directed checks cover reset, grant lock, full lanes, TDM stall and clear.

module tb_geared_stream_collect_buf;

    localparam int NL = 4;
    localparam int DP = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              rr_clr, rr_rdy, rr_vo;
    logic [NL-1:0]     rr_vi, rr_ro;
    logic [NL-1:0][7:0] rr_di;
    logic [7:0]        rr_do;
    logic [1:0]        rr_slot;

    logic              td_clr, td_rdy, td_vo;
    logic [NL-1:0]     td_vi, td_ro;
    logic [NL-1:0][7:0] td_di;
    logic [7:0]        td_do;
    logic [1:0]        td_slot;

`ifdef GEARED_COLLECT_BUF_OCCUPANCY_EN
    logic [NL-1:0][1:0] rr_fill, td_fill;
`endif

    geared_stream_collect_buf #(.NumLanes(NL), .Depth(DP), .Mode(0), .T(logic [7:0])) u_rr (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(rr_clr),
        .valid_i(rr_vi), .ready_o(rr_ro), .data_i(rr_di),
        .valid_o(rr_vo), .ready_i(rr_rdy), .data_o(rr_do), .slot_o(rr_slot)
`ifdef GEARED_COLLECT_BUF_OCCUPANCY_EN
        , .fill_o(rr_fill)
`endif
    );

    geared_stream_collect_buf #(.NumLanes(NL), .Depth(DP), .Mode(1), .T(logic [7:0])) u_td (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(td_clr),
        .valid_i(td_vi), .ready_o(td_ro), .data_i(td_di),
        .valid_o(td_vo), .ready_i(td_rdy), .data_o(td_do), .slot_o(td_slot)
`ifdef GEARED_COLLECT_BUF_OCCUPANCY_EN
        , .fill_o(td_fill)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [9:0] rr_q[$];   // {slot, data}
    logic [9:0] td_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Output monitors: a handshake seen at the negedge completes on the next
    // rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rr_vo && rr_rdy) begin
                if (rr_q.size() == 0) chk("rr_unexpected_beat", rr_q.size(), 1);
                else                  chk("rr_beat", {22'b0, rr_slot, rr_do}, {22'b0, rr_q.pop_front()});
            end
            if (td_vo && td_rdy) begin
                if (td_q.size() == 0) chk("td_unexpected_beat", td_q.size(), 1);
                else                  chk("td_beat", {22'b0, td_slot, td_do}, {22'b0, td_q.pop_front()});
            end
        end
    end

    initial begin
        rr_clr = 0; rr_rdy = 0; rr_vi = '0; rr_di = '0;
        td_clr = 0; td_rdy = 0; td_vi = '0; td_di = '0;

        // ---------------- reset ----------------
        repeat (2) cyc();
        smp();
        chk("rr_rst_valid", rr_vo, 0);
        chk("rr_rst_ready", rr_ro, 4'hf);
        chk("rr_rst_slot", rr_slot, 0);
        chk("td_rst_valid", td_vo, 0);
        chk("td_rst_ready", td_ro, 4'hf);
        chk("td_rst_slot", td_slot, 0);
        cyc();
        rst_n = 1;
        cyc();

        // ---------------- round-robin fairness ----------------
        rr_rdy = 1;
        rr_vi  = 4'hf;
        for (int i = 0; i < NL; i++) begin
            rr_di[i] = 8'(i);
            rr_q.push_back({2'(i), 8'(i)});
        end
        smp();
        chk("rr_no_fallthrough", rr_vo, 0);
        cyc();
        rr_vi = '0;
        repeat (4) cyc();
        smp();
        chk("rr_fair_idle", rr_vo, 0);
        chk("rr_ptr_wrap", rr_slot, 0);

        // ---------------- grant lock ----------------
        cyc();
        rr_vi = 4'b0001; rr_di[0] = 8'h10; rr_q.push_back({2'd0, 8'h10});
        cyc();
        rr_vi = '0;                      // lane 0 served on next edge, ptr -> 1
        cyc();
        rr_rdy = 0;
        rr_vi = 4'b0100; rr_di[2] = 8'h22; rr_q.push_back({2'd2, 8'h22});
        cyc();
        rr_vi = '0;
        smp();
        chk("rr_lock_valid", rr_vo, 1);
        chk("rr_lock_slot0", rr_slot, 2);
        chk("rr_lock_data0", rr_do, 8'h22);
        cyc();
        rr_vi = 4'b0010; rr_di[1] = 8'h11; rr_q.push_back({2'd1, 8'h11});
        smp();
        chk("rr_lock_slot1", rr_slot, 2);
        cyc();
        rr_vi = '0;
        smp();
        chk("rr_lock_slot2", rr_slot, 2);
        chk("rr_lock_data2", rr_do, 8'h22);
        cyc();
        rr_rdy = 1;
        repeat (3) cyc();
        smp();
        chk("rr_lock_drained", rr_vo, 0);

        // ---------------- full lane / backpressure ----------------
        cyc();
        rr_rdy = 0;
        rr_vi = 4'b0001; rr_di[0] = 8'hA0; rr_q.push_back({2'd0, 8'hA0});
        cyc();
        rr_di[0] = 8'hA1; rr_q.push_back({2'd0, 8'hA1});
        smp();
        chk("rr_ready_one", rr_ro[0], 1);
        cyc();
        rr_di[0] = 8'hA2; rr_q.push_back({2'd0, 8'hA2});
        smp();
        chk("rr_full", rr_ro[0], 0);
        cyc();
        rr_rdy = 1;                      // one pop; A2 still refused this edge
        smp();
        chk("rr_full_held", rr_ro[0], 0);
        cyc();
        rr_rdy = 0;
        smp();
        chk("rr_pop_reopens", rr_ro[0], 1);
`ifdef GEARED_COLLECT_BUF_OCCUPANCY_EN
        chk("rr_fill_one", rr_fill[0], 1);
`endif
        cyc();
        rr_vi = '0;                      // A2 accepted on the previous edge
        smp();
        chk("rr_refilled", rr_ro[0], 0);
        rr_rdy = 1;
        repeat (3) cyc();
        smp();
        chk("rr_full_drained", rr_vo, 0);

        // ---------------- clear mid-traffic ----------------
        cyc();
        rr_rdy = 0;
        rr_vi = 4'b0111; rr_di[0] = 8'h30; rr_di[1] = 8'h31; rr_di[2] = 8'h32;
        cyc();
        rr_vi = 4'b0001; rr_di[0] = 8'h40;
        cyc();
        rr_vi = 4'b0001; rr_di[0] = 8'h41; rr_clr = 1;
        smp();
        chk("rr_pre_clr_slot", rr_slot, 1);
        cyc();
        rr_clr = 0; rr_vi = '0;
        smp();
        chk("rr_clr_valid", rr_vo, 0);
        chk("rr_clr_ready", rr_ro, 4'hf);
        chk("rr_clr_slot", rr_slot, 0);
`ifdef GEARED_COLLECT_BUF_OCCUPANCY_EN
        chk("rr_clr_fill", rr_fill, 0);
`endif
        // Only this beat may appear after the clear.
        cyc();
        rr_rdy = 1;
        rr_vi = 4'b1000; rr_di[3] = 8'h55; rr_q.push_back({2'd3, 8'h55});
        cyc();
        rr_vi = '0;
        repeat (3) cyc();

        // ---------------- TDM stall ----------------
        td_rdy = 0;
        td_vi = 4'b0010; td_di[1] = 8'hAA; td_q.push_back({2'd1, 8'hAA});
        cyc();
        td_vi = '0;
        repeat (5) cyc();
        smp();
        chk("td_stall_slot0", td_slot, 1);
        chk("td_stall_valid", td_vo, 1);
        chk("td_stall_data0", td_do, 8'hAA);
        cyc();
        smp();
        chk("td_stall_slot1", td_slot, 1);
        chk("td_stall_data1", td_do, 8'hAA);
        cyc();
        td_rdy = 1;
        cyc();
        smp();
        chk("td_advance", td_slot, 2);
        chk("td_empty_slot", td_vo, 0);
        cyc();
        smp();
        chk("td_skip_one", td_slot, 3);

        // ---------------- drain check ----------------
        repeat (4) cyc();
        chk("rr_queue_drained", rr_q.size(), 0);
        chk("td_queue_drained", td_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
